// File: rtl/config_tree_result_unpacker_pkg.sv
// Shared types and helpers for the tree-adder result unpacker.
// Holds the FSM state encoding, the lane codes and the half-field sign extension.
package config_tree_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_LO = 2'd1,
        EMIT_HI = 2'd2
    } state_e;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Widest W the helper below supports.
    localparam int MAX_W = 64;

    // Sign-extends the low w/2 bits of field into a w-bit value (upper bits above w are 0).
    function automatic logic [MAX_W-1:0] sext_half(input logic [MAX_W-1:0] field, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w / 2)
                r[i] = field[i];
            else if (i < w)
                r[i] = field[w/2-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/config_tree_result_unpacker.sv
// Streaming unpacker for the configurable adder tree: one packed word in, one (full)
// or two (halved) sign-extended results out, with registered outputs and valid/ready.
module config_tree_result_unpacker
    import config_tree_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         in_halved_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         out_lane_o,
    output logic         out_last_o
);

    state_e           state_q, state_d;
    logic [W/2-1:0]   hold_hi_q, hold_hi_d;
    logic             hold_halved_q, hold_halved_d;
    logic [W-1:0]     data_q, data_d;
    logic             lane_q, lane_d;
    logic             last_q, last_d;

    logic             accept;
    logic             take;
    logic [W-1:0]     in_lo_sext;
    logic [W-1:0]     hold_hi_sext;

    assign in_lo_sext   = W'(sext_half(MAX_W'(in_data_i[W/2-1:0]), W));
    assign hold_hi_sext = W'(sext_half(MAX_W'(hold_hi_q), W));

    assign out_valid_o = (state_q != IDLE);
    assign out_data_o  = data_q;
    assign out_lane_o  = lane_q;
    assign out_last_o  = last_q;

    // Accepting while the final beat leaves avoids a bubble between words.
    assign in_ready_o = rst_ni & ((state_q == IDLE) | (out_ready_i & last_q));
    assign accept     = in_valid_i & in_ready_o;
    assign take       = out_valid_o & out_ready_i;

    always_comb begin
        state_d       = state_q;
        hold_hi_d     = hold_hi_q;
        hold_halved_d = hold_halved_q;
        data_d        = data_q;
        lane_d        = lane_q;
        last_d        = last_q;

        if (take && state_q == EMIT_LO && hold_halved_q) begin
            state_d = EMIT_HI;
            data_d  = hold_hi_sext;
            lane_d  = LANE_HI;
            last_d  = 1'b1;
        end else if (accept) begin
            // accept implies IDLE or the last beat leaving this cycle
            state_d       = EMIT_LO;
            hold_hi_d     = in_data_i[W-1:W/2];
            hold_halved_d = in_halved_i;
            data_d        = in_halved_i ? in_lo_sext : in_data_i;
            lane_d        = LANE_LO;
            last_d        = ~in_halved_i;
        end else if (take) begin
            state_d = IDLE;
            data_d  = '0;
            lane_d  = LANE_LO;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            hold_hi_q     <= '0;
            hold_halved_q <= 1'b0;
            data_q        <= '0;
            lane_q        <= LANE_LO;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_hi_q     <= hold_hi_d;
            hold_halved_q <= hold_halved_d;
            data_q        <= data_d;
            lane_q        <= lane_d;
            last_q        <= last_d;
        end
    end

endmodule

// File: tb/tb_config_tree_result_unpacker.sv
// Scoreboard bench for config_tree_result_unpacker (W=16) with directed vectors.
module tb_config_tree_result_unpacker;

    localparam int W = 16;

    logic         clk;
    logic         rst_ni;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_halved;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_lane;
    logic         out_last;

    typedef struct {
        logic [W-1:0] data;
        logic         lane;
        logic         last;
        logic         consec;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    prev_pop_cyc = -10;
    int    beats_seen = 0;

    config_tree_result_unpacker #(.W(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_halved_i (in_halved),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_lane_o  (out_lane),
        .out_last_o  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a beat transfers at the next posedge when valid && ready are seen here.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_ni && out_valid && out_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h lane %b last %b expected none",
                             out_data, out_lane, out_last);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_lane", W'(out_lane), W'(e.lane));
                    check("beat_last", W'(out_last), W'(e.last));
                    if (e.consec)
                        check("beat_no_bubble", W'(cyc - prev_pop_cyc), W'(1));
                end
                prev_pop_cyc = cyc;
            end
        end
    end

    // Drives one word; returns right after the accepting posedge.
    task automatic send(input logic [W-1:0] w, input logic h,
                        input logic [W-1:0] e0, input logic [W-1:0] e1,
                        input logic c0, input logic c1);
        int n;
        beat_t b;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = w;
        in_halved = h;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %h not accepted, in_ready %b expected 1", w, in_ready);
        end else begin
            b.data = e0; b.lane = 1'b0; b.last = ~h; b.consec = c0;
            exp_q.push_back(b);
            if (h) begin
                b.data = e1; b.lane = 1'b1; b.last = 1'b1; b.consec = c1;
                exp_q.push_back(b);
            end
            @(posedge clk);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = 16'hDEAD;
        in_halved = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    initial begin
        rst_ni    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_halved = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data",  out_data, 16'h0000);
        check("rst_out_lane",  W'(out_lane), W'(0));
        check("rst_out_last",  W'(out_last), W'(0));
        check("rst_in_ready",  W'(in_ready), W'(0));
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", W'(in_ready), W'(1));

        // full word, in_ready seen high while its beat is taken
        send(16'h8001, 1'b0, 16'h8001, 16'h0000, 1'b0, 1'b0);
        idle_in();
        #3;
        check("full_beat_valid", W'(out_valid), W'(1));
        check("full_in_ready_on_take", W'(in_ready), W'(1));
        drain();

        // halved word
        send(16'h7F80, 1'b1, 16'hFF80, 16'h007F, 1'b0, 1'b1);
        idle_in();
        drain();

        // back-to-back full words
        send(16'h0001, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);
        send(16'h0002, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0);
        send(16'h0003, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0);
        idle_in();
        drain();

        // back-to-back halved words
        send(16'h0101, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1);
        send(16'hFEFE, 1'b1, 16'hFFFE, 16'hFFFE, 1'b1, 1'b1);
        idle_in();
        drain();

        // backpressure during the high field
        send(16'h80FF, 1'b1, 16'hFFFF, 16'hFF80, 1'b0, 1'b0);
        idle_in();
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            check("bp_valid",    W'(out_valid), W'(1));
            check("bp_data",     out_data, 16'hFF80);
            check("bp_lane",     W'(out_lane), W'(1));
            check("bp_last",     W'(out_last), W'(1));
            check("bp_in_ready", W'(in_ready), W'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // mixed precision, no drain between words
        send(16'h01FF, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        send(16'h1234, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0);
        idle_in();
        drain();

        // reset while the low field of a halved word is held
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h5A5A, 1'b1, 16'h005A, 16'h005A, 1'b0, 1'b0);
        idle_in();
        #3;
        check("pre_rst_valid", W'(out_valid), W'(1));
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("midrst_valid",    W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(0));
        exp_q.delete();
        @(negedge clk);
        rst_ni    = 1'b1;
        out_ready = 1'b1;
        #1;
        check("after_rst_valid", W'(out_valid), W'(0));
        beats_seen = 0;
        send(16'h00AA, 1'b0, 16'h00AA, 16'h0000, 1'b0, 1'b0);
        idle_in();
        drain();
        repeat (4) @(negedge clk);
        check("after_rst_beat_count", W'(beats_seen), W'(1));
        check("final_idle_valid", W'(out_valid), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
